// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and scanout FSM states shared by the SPI receive slave and scanout.
package fb_pkg;
  localparam int FB_WIDTH   = 96;
  localparam int FB_HEIGHT  = 64;
  localparam int WORD_WIDTH = 16;
  localparam int WORD_COUNT = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W  = $clog2(WORD_COUNT);
  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_FETCH, S_LOAD, S_SHIFT, S_CS_HOLD, S_DONE
  } scan_state_e;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: SPI mode-0 word serialiser, MSB first, sck idles low.
module spi_tx_shifter #(
  parameter int WORD_WIDTH = fb_pkg::WORD_WIDTH,
  parameter int SCK_HALF   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  start_i,
  output logic                  sck_o,
  output logic                  mosi_o,
  output logic                  done_o
);
  import fb_pkg::*;
  localparam int DW = addr_w(SCK_HALF);
  localparam int BW = addr_w(WORD_WIDTH);
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic sck_q, sck_d, mosi_q, mosi_d, phase_end;
  assign phase_end = start_i && div_q == DW'(SCK_HALF - 1);
  assign done_o    = phase_end && sck_q && bit_q == '0;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  always_comb begin
    sh_d   = sh_q;
    bit_d  = bit_q;
    div_d  = div_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    if (clr_i) begin
      sck_d  = 1'b0;
      mosi_d = 1'b0;
      div_d  = '0;
    end else if (load_i) begin
      sh_d   = word_i;
      mosi_d = word_i[WORD_WIDTH-1];
      bit_d  = BW'(WORD_WIDTH - 1);
      div_d  = '0;
      sck_d  = 1'b0;
    end else if (start_i) begin
      div_d = phase_end ? '0 : div_q + DW'(1);
      sck_d = sck_q ^ phase_end;
      // falling edge: advance to the next bit so it is stable before the next rise
      if (phase_end && sck_q && !done_o) begin
        sh_d   = sh_q << 1;
        mosi_d = sh_q[WORD_WIDTH-2];
        bit_d  = bit_q - BW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bit_q  <= '0;
      div_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      div_q  <= div_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
    end
  end
endmodule

// File: rtl/fb_spi_scanout.sv
// fb_spi_scanout: reads the framebuffer in address order and streams it to the OLED over SPI,
// one chip-select frame per frame_start.
module fb_spi_scanout #(
  parameter int WORD_WIDTH = fb_pkg::WORD_WIDTH,
  parameter int WORD_COUNT = fb_pkg::WORD_COUNT,
  parameter int SCK_HALF   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   frame_start_i,
  input  logic                                   abort_i,
  output logic                                   busy_o,
  output logic                                   frame_done_o,
  output logic                                   fb_rd_en_o,
  output logic [fb_pkg::addr_w(WORD_COUNT)-1:0] fb_addr_o,
  input  logic [WORD_WIDTH-1:0]                  fb_data_i,
  output logic                                   oled_cs_n_o,
  output logic                                   oled_sck_o,
  output logic                                   oled_mosi_o
);
  import fb_pkg::*;
  localparam int AW = addr_w(WORD_COUNT);
  localparam int CW = addr_w(SCK_HALF);
  scan_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, done_q, rd_en_q, cs_n_q, tx_done, last_word, tx_clr;
  assign last_word = addr_q == AW'(WORD_COUNT - 1);
  assign tx_clr    = state_d inside {S_IDLE, S_DONE};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (abort_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (frame_start_i) begin
        state_d = S_CS_SETUP;
        addr_d  = '0;
      end
      S_CS_SETUP: if (cnt_q == CW'(SCK_HALF - 1)) state_d = S_FETCH;
      S_FETCH:    state_d = S_LOAD;
      S_LOAD:     state_d = S_SHIFT;
      S_SHIFT: if (tx_done) begin
        state_d = last_word ? S_CS_HOLD : S_FETCH;
        addr_d  = last_word ? addr_q : addr_q + AW'(1);
      end
      S_CS_HOLD:  if (cnt_q == CW'(SCK_HALF - 1)) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
    // dwell counter restarts on every state change
    cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_d == S_DONE;
      rd_en_q <= state_d == S_FETCH;
      cs_n_q  <= state_d inside {S_IDLE, S_DONE};
    end
  end
  spi_tx_shifter #(.WORD_WIDTH(WORD_WIDTH), .SCK_HALF(SCK_HALF)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tx_clr),
    .load_i (state_q == S_LOAD),
    .word_i (fb_data_i),
    .start_i(state_q == S_SHIFT),
    .sck_o  (oled_sck_o),
    .mosi_o (oled_mosi_o),
    .done_o (tx_done)
  );
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign fb_rd_en_o   = rd_en_q;
  assign fb_addr_o    = addr_q;
  assign oled_cs_n_o  = cs_n_q;
endmodule

// File: tb/tb_fb_spi_scanout.sv
// tb_fb_spi_scanout: directed bench with a RAM model and a word scoreboard fed by an SPI decoder.
module tb_fb_spi_scanout;
  localparam int WW = 16;
  localparam int WC = 128;
  localparam int SH = 2;
  localparam int AW = $clog2(WC);
  localparam int FRAME_CYC = SH + WC * (2 + 2 * SH * WW) + SH + 1;
  logic clk = 1'b0, rst_n = 1'b0, frame_start_i = 1'b0, abort_i = 1'b0;
  logic busy_o, frame_done_o, fb_rd_en_o, oled_cs_n_o, oled_sck_o, oled_mosi_o;
  logic [AW-1:0] fb_addr_o;
  logic [WW-1:0] fb_data_i = '0;
  int passed = 0, failed = 0, total = 0;
  logic [WW-1:0] exp_q[$];
  int exp_addr = 0, rd_count = 0, dec_words = 0, dec_bits = 0;
  logic [WW-1:0] dec_acc = '0;
  logic sck_prev = 1'b0;

  always #5 clk = ~clk;

  fb_spi_scanout #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .SCK_HALF(SH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i), .abort_i(abort_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .fb_rd_en_o(fb_rd_en_o),
    .fb_addr_o(fb_addr_o), .fb_data_i(fb_data_i), .oled_cs_n_o(oled_cs_n_o),
    .oled_sck_o(oled_sck_o), .oled_mosi_o(oled_mosi_o)
  );

  // word 0 is 16'hA5C3; data is garbage except the cycle after a read strobe
  function automatic logic [WW-1:0] pix(input int i);
    return WW'(32'hA5C3 ^ (i * 257));
  endfunction

  always @(posedge clk) fb_data_i <= fb_rd_en_o ? pix(int'(fb_addr_o)) : WW'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // panel-side decoder: sample mosi on each sck rise, compare whole words against the scoreboard
  always @(negedge clk) begin
    if (!rst_n || oled_cs_n_o) dec_bits = 0;
    else if (oled_sck_o && !sck_prev) begin
      dec_acc = {dec_acc[WW-2:0], oled_mosi_o};
      dec_bits++;
      if (dec_bits == WW) begin
        dec_bits = 0;
        dec_words++;
        check("word_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word_data", 32'(dec_acc), 32'(exp_q.pop_front()));
      end
    end
    sck_prev = oled_sck_o;
    if (rst_n && fb_rd_en_o) begin
      check("fb_addr", 32'(fb_addr_o), 32'(exp_addr));
      exp_addr++;
      rd_count++;
    end
  end

  task automatic arm_frame();
    exp_addr  = 0;
    rd_count  = 0;
    dec_words = 0;
    for (int i = 0; i < WC; i++) exp_q.push_back(pix(i));
  endtask

  task automatic run_frame(input int inj_a, input int inj_b);
    int cyc = 0, cs_low = 0, dones = 0;
    arm_frame();
    frame_start_i = 1'b1;
    for (int i = 1; i <= FRAME_CYC + 100; i++) begin
      @(negedge clk);
      frame_start_i = fb_rd_en_o && (int'(fb_addr_o) == inj_a || int'(fb_addr_o) == inj_b);
      if (i == 1) check("busy_after_accept", 32'(busy_o), 32'd1);
      if (!oled_cs_n_o) cs_low++;
      if (frame_done_o) begin
        cyc = i;
        dones++;
        check("done_cs_mosi", 32'({oled_cs_n_o, oled_mosi_o}), 32'b10);
        break;
      end
    end
    frame_start_i = 1'b0;
    check("frame_cycles", 32'(cyc), 32'(FRAME_CYC));
    check("cs_low_cycles", 32'(cs_low), 32'(FRAME_CYC - 1));
    @(negedge clk);
    check("idle_after", 32'({busy_o, oled_cs_n_o, oled_sck_o, frame_done_o}), 32'b0100);
    repeat (20) begin
      @(negedge clk);
      if (frame_done_o) dones++;
    end
    check("done_pulses", 32'(dones), 32'd1);
    check("rd_en_count", 32'(rd_count), 32'(WC));
    check("words_decoded", 32'(dec_words), 32'(WC));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({oled_cs_n_o, oled_sck_o, oled_mosi_o, busy_o, frame_done_o, fb_rd_en_o}), 32'b100000);
    check("rst_addr", 32'(fb_addr_o), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!oled_cs_n_o || oled_sck_o || busy_o || fb_rd_en_o || frame_done_o) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    run_frame(-1, -1);
    run_frame(10, 100);

    // abort while bit 7 of word 100 is on the wire
    arm_frame();
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
    for (int i = 0; i < 20000 && !(dec_words == 100 && dec_bits == 9); i++) @(negedge clk);
    check("abort_point", 32'(dec_words * WW + dec_bits), 32'(100 * WW + 9));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_outputs", 32'({oled_cs_n_o, oled_sck_o, oled_mosi_o, busy_o, fb_rd_en_o}), 32'b10000);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done_o || !oled_cs_n_o || busy_o) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    check("abort_words", 32'(dec_words), 32'd100);
    exp_q.delete();
    run_frame(-1, -1);

    // abort beats frame_start in IDLE
    frame_start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
    abort_i = 1'b0;
    bad = 0;
    repeat (10) begin
      if (busy_o || !oled_cs_n_o || fb_rd_en_o) bad++;
      @(negedge clk);
    end
    check("abort_wins_idle", 32'(bad), 32'd0);

    // asynchronous reset in the middle of a word
    arm_frame();
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
    for (int i = 0; i < 20000 && !(fb_addr_o == AW'(5) && oled_sck_o); i++) @(negedge clk);
    check("reset_point", 32'({fb_addr_o, oled_sck_o}), 32'({AW'(5), 1'b1}));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({oled_cs_n_o, oled_sck_o, oled_mosi_o, busy_o, fb_rd_en_o}), 32'b10000);
    check("async_reset_addr", 32'(fb_addr_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_done_o || busy_o) bad++;
    end
    check("reset_quiet", 32'(bad), 32'd0);
    run_frame(-1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fb_spi_scanout.md
Name: fb_spi_scanout

Overview:
- Downstream consumer of the 96x64 RGB565 framebuffer that is filled by the SPI receive slave.
- On a frame_start pulse, reads all framebuffer words in address order through the framebuffer's synchronous read port.
- Serialises each word as an SPI mode-0 master stream to the OLED panel, MSB first, with chip select framing one full frame.
- Sits between the framebuffer block-RAM read port and the panel pins.

Parameters:
- WORD_WIDTH, 16, bits per pixel word.
- WORD_COUNT, 6144, words per frame (96*64).
- SCK_HALF, 2, clk cycles per SCK half-period; legal range 1 and above.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- abort  in  1  synchronous abort of the current frame.
- busy  out  1  high from the cycle after frame_start is accepted until back in IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- fb_rd_en  out  1  read strobe to the framebuffer.
- fb_addr  out  $clog2(WORD_COUNT)  framebuffer read address.
- fb_data  in  WORD_WIDTH  read data; valid exactly 1 cycle after fb_rd_en.
- oled_cs_n  out  1  panel chip select, active low.
- oled_sck  out  1  panel SPI clock, idles low.
- oled_mosi  out  1  panel SPI data.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, busy=0, frame_done=0, fb_rd_en=0, fb_addr=0.
  - oled_cs_n=1, oled_sck=0, oled_mosi=0.
  - All outputs are registered.
- States: IDLE, CS_SETUP, FETCH, LOAD, SHIFT, CS_HOLD, DONE.
- IDLE, on frame_start=1:
  - Next state CS_SETUP.
  - oled_cs_n goes low; word counter and fb_addr clear to 0.
- CS_SETUP: hold SCK_HALF cycles with sck=0, then go to FETCH.
- FETCH: fb_rd_en=1 for one cycle with fb_addr = current word index, then go to LOAD.
- LOAD:
  - Capture fb_data into the shift register.
  - Drive oled_mosi = fb_data[WORD_WIDTH-1]; go to SHIFT with bit counter = WORD_WIDTH-1.
- SHIFT:
  - Each bit is SCK_HALF cycles with sck=0, then SCK_HALF cycles with sck=1.
  - On the falling transition the shift register advances and mosi presents the next bit; the panel samples on the rising edge.
  - After bit 0's high phase, sck returns low.
  - If the word index equals WORD_COUNT-1, go to CS_HOLD. Otherwise increment fb_addr and go to FETCH.
  - The fixed 2-cycle inter-word gap (FETCH, LOAD) holds sck low.
- CS_HOLD: SCK_HALF cycles with sck=0 and cs_n still low, then go to DONE.
- DONE:
  - oled_cs_n=1, frame_done=1 for one cycle, mosi=0.
  - Next state IDLE; busy drops in the same cycle as the IDLE entry.
- Frame length from accept to frame_done:
  - Total cycles = SCK_HALF + WORD_COUNT*(2 + 2*SCK_HALF*WORD_WIDTH) + SCK_HALF + 1.
  - With defaults this is 2 + 6144*66 + 2 + 1 = 405509 cycles.
- Bit order: word MSB first; the word is transmitted exactly as stored, high byte first on the wire.
- frame_start while busy: ignored, with no queueing.
- frame_start and abort in the same cycle in IDLE: abort wins and the frame does not start.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, cs_n=1, sck=0, mosi=0, fb_rd_en=0.
  - No frame_done pulse.
  - A partial word is discarded.
- rst_n asserted mid-frame: outputs go to reset values immediately (asynchronous); no frame_done pulse.
- Address wrap: fb_addr never exceeds WORD_COUNT-1 and restarts at 0 on each frame.
- fb_data is ignored outside the LOAD cycle.

Decomposition:
- Shared package fb_pkg:
  - FB_WIDTH=96, FB_HEIGHT=64, WORD_WIDTH=16, WORD_COUNT=FB_WIDTH*FB_HEIGHT.
  - FB_ADDR_W=$clog2(WORD_COUNT).
  - State enum for the scanout FSM.
  - These constants are shared with the SPI receive slave.
- One sub-module, spi_tx_shifter:
  - Ports: load, word, start; outputs sck, mosi, done.
  - Owns the SCK_HALF divider, bit counter and shift register.
  - The top level owns the FSM, addressing and chip-select framing.

Test Plan:
- Reset and idle:
  - Hold rst_n=0 then release with no stimulus.
  - Required: cs_n=1, sck=0, busy=0, no fb_rd_en for 1000 cycles.
- Single word, WORD_COUNT=1, SCK_HALF=2, fb_data=16'hA5C3:
  - Pulse frame_start.
  - Required: mosi sampled on the 16 sck rising edges reads 1010010111000011.
  - Required: cs_n low for exactly 2+66+2 cycles, frame_done 71 cycles after accept.
- Full default frame, RAM model word[i]=i:
  - Required: 6144 words are decoded in order 0..6143, fb_addr is sequential, and fb_rd_en fires 6144 times.
  - Required: frame_done at cycle 405509.
- frame_start pulsed at words 10 and 3000 mid-frame:
  - Required: ignored, exactly one frame_done, identical decoded data.
- abort during word 100, bit 7:
  - Required: next cycle cs_n=1, sck=0, busy=0, no frame_done.
  - Required: a subsequent frame_start restarts from fb_addr=0.
- rst_n pulsed low mid-SHIFT:
  - Required: cs_n=1 and sck=0 in the same cycle (asynchronous).
  - Required: after release, a new frame reads from address 0.
